// File: rtl/instr_loader.sv
// instr_loader: packs UART bytes MSB-first into instruction words, writes them at consecutive
// word addresses until HALT_WORD, then releases the core. Optional checksum: `LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for i_start after reset
// LOAD  | assembling bytes into words and writing them
// CHECK | waiting for the trailing checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | load finished; enable raised when clean

module instr_loader #(
  parameter int                 NB_ADDR   = 32,
  parameter int                 NB_INST   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 MEM_DEPTH = 64,
  parameter logic [NB_INST-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_write,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_address,
  output logic               o_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic               o_error
);

  localparam int                 SHIFT_W  = NB_INST - NB_BYTE;
  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           byte_cnt;
  logic [SHIFT_W-1:0]   shift_q;
  logic [NB_ADDR-1:0]   ptr;
  logic                 ovf_q;
  logic [NB_INST-1:0]   word_in;
  logic                 start_load;

  assign word_in    = {shift_q, i_rx_data};
  assign start_load = i_start && (state == IDLE || state == DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum_q;
`else
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      byte_cnt      <= 2'd0;
      shift_q       <= '0;
      ptr           <= '0;
      ovf_q         <= 1'b0;
      o_write       <= 1'b0;
      o_instruction <= '0;
      o_address     <= '0;
      o_enable      <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_overflow    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      o_error       <= 1'b0;
      csum_q        <= '0;
`endif
    end else begin
      o_write <= 1'b0;
      if (start_load) begin
        state      <= LOAD;
        byte_cnt   <= 2'd0;
        shift_q    <= '0;
        ptr        <= '0;
        ovf_q      <= 1'b0;
        o_address  <= '0;
        o_enable   <= 1'b0;
        o_busy     <= 1'b1;
        o_done     <= 1'b0;
        o_overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        o_error    <= 1'b0;
        csum_q     <= '0;
`endif
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (i_rx_valid) begin
              byte_cnt <= byte_cnt + 2'd1;
              shift_q  <= {shift_q[SHIFT_W-NB_BYTE-1:0], i_rx_data};
`ifdef LOADER_CHECKSUM_EN
              csum_q   <= csum_q ^ i_rx_data;
`endif
              if (byte_cnt == 2'd3) begin
                o_write       <= 1'b1;
                o_instruction <= word_in;
                o_address     <= ptr << 2;
                ptr           <= ptr + NB_ADDR'(1);
                if (word_in == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= CHECK;
`else
                  state <= DONE;
`endif
                end else if (ptr == LAST_IDX) begin
                  ovf_q <= 1'b1;
                  state <= DONE;
                end
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            if (i_rx_valid) begin
              state    <= DONE;
              o_done   <= 1'b1;
              o_busy   <= 1'b0;
              o_error  <= (i_rx_data != csum_q);
              o_enable <= (i_rx_data == csum_q);
            end
          end
`endif
          DONE: begin
            // Status is published one cycle after the final write, so it never overlaps o_write.
            if (!o_done) begin
              o_done     <= 1'b1;
              o_busy     <= 1'b0;
              o_overflow <= ovf_q;
              o_enable   <= !ovf_q;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader against a word-list reference model (MEM_DEPTH=4).
module tb_instr_loader;
  localparam int DEPTH = 4;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {logic [31:0] w; logic [31:0] a; int c;} wr_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        o_write, o_enable, o_busy, o_done, o_overflow, o_error;
  logic [31:0] o_instruction, o_address;

  instr_loader #(.MEM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_write(o_write), .o_instruction(o_instruction), .o_address(o_address), .o_enable(o_enable),
    .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow), .o_error(o_error));

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;
  int cyc = 0;
  wr_t wq[$];
  bit  done_seen = 0;
  int  done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_write) wq.push_back('{o_instruction, o_address, cyc});
    if (o_done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_w[$];
  bit          exp_ovf, exp_end;
  logic [7:0]  exp_csum;
`ifdef LOADER_CHECKSUM_EN
  bit          csum_corrupt = 0;
`endif

  // Reference: split stream into 4-byte big-endian words; stop at the sentinel or when memory is full.
  function automatic void model(input byte_q_t b);
    logic [31:0] w;
    exp_w.delete();
    exp_ovf  = 0;
    exp_end  = 0;
    exp_csum = 8'h00;
    for (int i = 0; i + 3 < b.size() && !exp_end; i += 4) begin
      w = {b[i], b[i+1], b[i+2], b[i+3]};
      exp_csum = exp_csum ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
      exp_w.push_back(w);
      if (w == 32'hFFFF_FFFF) exp_end = 1;
      else if (exp_w.size() == DEPTH) begin
        exp_ovf = 1;
        exp_end = 1;
      end
    end
  endfunction

  task automatic send(input byte_q_t b, input int maxgap, input int start_at);
    foreach (b[i]) begin
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        repeat (g) begin
          rx_valid = 0;
          start    = 0;
          @(negedge clk);
        end
      end
      rx_data  = b[i];
      rx_valid = 1;
      start    = (i == start_at);
      @(negedge clk);
    end
    rx_valid = 0;
    start    = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_busy", o_busy, 1);
    check("start_done_clr", o_done, 0);
    check("start_enable_clr", o_enable, 0);
    check("start_addr_clr", o_address, 0);
    wq.delete();
    done_seen = 0;
  endtask

  task automatic run_and_check(input string tag, input byte_q_t b, input int maxgap,
                               input bit spacing, input int start_at);
    bit exp_en;
    model(b);
    send(b, maxgap, start_at);
    exp_en = !exp_ovf;
`ifdef LOADER_CHECKSUM_EN
    if (!exp_ovf) begin
      byte_q_t cb;
      cb.push_back(csum_corrupt ? (exp_csum ^ 8'h01) : exp_csum);
      send(cb, 2, -1);
      exp_en = !csum_corrupt;
    end
`endif
    for (int k = 0; k < 40 && !done_seen; k++) @(negedge clk);
    check({tag, "_done_seen"}, done_seen, 1);
    repeat (2) @(negedge clk);
    check({tag, "_nwrites"}, wq.size(), exp_w.size());
    foreach (exp_w[i]) begin
      if (i < wq.size()) begin
        check({tag, "_word"}, wq[i].w, exp_w[i]);
        check({tag, "_addr"}, wq[i].a, 32'(i * 4));
        if (spacing && i > 0) check({tag, "_spacing"}, wq[i].c - wq[i-1].c, 4);
      end
    end
`ifndef LOADER_CHECKSUM_EN
    if (wq.size() > 0) check({tag, "_done_latency"}, done_cyc - wq[wq.size()-1].c, 1);
`else
    if (exp_ovf && wq.size() > 0) check({tag, "_done_latency"}, done_cyc - wq[wq.size()-1].c, 1);
    check({tag, "_error"}, o_error, !exp_ovf && csum_corrupt);
`endif
    check({tag, "_done"}, o_done, 1);
    check({tag, "_enable"}, o_enable, exp_en);
    check({tag, "_overflow"}, o_overflow, exp_ovf);
    check({tag, "_busy"}, o_busy, 0);
`ifndef LOADER_CHECKSUM_EN
    check({tag, "_error"}, o_error, 0);
`endif
  endtask

  function automatic byte_q_t rand_prog();
    byte_q_t p;
    int      nw;
    bit      halt;
    nw   = $urandom_range(6, 1);
    halt = (nw < 4) || ($urandom_range(1, 0) == 1);
    for (int i = 0; i < nw; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (halt && i == nw - 1) p.push_back(8'hFF);
        else p.push_back(8'($urandom_range(255, 0)));
      end
    end
    return p;
  endfunction

  initial begin
    byte_q_t p;
    int      n;
    repeat (3) @(negedge clk);
    check("rst_write", o_write, 0);
    check("rst_instr", o_instruction, 0);
    check("rst_addr", o_address, 0);
    check("rst_enable", o_enable, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_error", o_error, 0);
    rst_n = 1;
    @(negedge clk);

    p = {8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send(p, 0, -1);
    check("idle_ignores_bytes", wq.size(), 0);
    pulse_start();
    run_and_check("single", p, 0, 1, -1);

    // Restart from DONE with enable high, then back-to-back 12 bytes.
    p.delete();
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom_range(254, 0)));
    for (int i = 0; i < 4; i++) p.push_back(8'hFF);
    pulse_start();
    run_and_check("b2b", p, 0, 1, -1);

    p.delete();
    for (int i = 0; i < 16; i++) p.push_back(8'($urandom_range(254, 0)));
    pulse_start();
    run_and_check("overflow", p, 2, 0, -1);
    n = wq.size();
    p.delete();
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom_range(255, 0)));
    send(p, 0, -1);
    repeat (2) @(negedge clk);
    check("overflow_no_more_writes", wq.size(), n);

    p = rand_prog();
    pulse_start();
    run_and_check("start_in_load", p, 1, 0, 5);

    pulse_start();
    p = {8'hAA, 8'hBB};
    send(p, 0, -1);
    rst_n = 0;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_addr", o_address, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    p = {8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start();
    run_and_check("after_reset", p, 0, 1, -1);

`ifdef LOADER_CHECKSUM_EN
    p = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start();
    run_and_check("csum_good", p, 0, 0, -1);
    csum_corrupt = 1;
    pulse_start();
    run_and_check("csum_bad", p, 0, 0, -1);
    csum_corrupt = 0;
`endif

    for (int t = 0; t < 8; t++) begin
      p = rand_prog();
      pulse_start();
      run_and_check("random", p, (t % 2 == 0) ? 0 : 3, (t % 2 == 0), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
